clk_divider_bank: RTL and testbench

Parametrised bank of independent clock dividers, the successor to the fixed ten-output divider driving the user IO pads. Each of NCH channels divides `clk` by a runtime-programmable ratio. Each channel runs in square-wave or single-cycle-pulse mode and has its own enable. A new ratio takes effect only at a period boundary, so it never glitches. A global sync input realigns all running channels in phase. Outputs are registered and drive `io_out` pads directly.

---
 rtl/clk_divider_bank.sv | 125 ++++++++++++
 tb/tb_clk_divider_bank.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_divider_bank.sv
// Bank of NCH independent programmable clock dividers with glitch-free ratio
// updates at period boundaries and a shared phase-realignment input.
module clk_divider_bank #(
    parameter int NCH         = 10,
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 2
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [NCH-1:0]                           en,
    input  logic                                     sync_i,
    input  logic                                     cfg_we,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] cfg_ch,
    input  logic [WIDTH-1:0]                         cfg_div,
    input  logic                                     cfg_mode,
    output logic                                     cfg_err,
    output logic [NCH-1:0]                           cout,
    output logic [NCH-1:0]                           tick
);

    localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);

    logic [WIDTH-1:0] act_div_q  [NCH];
    logic [WIDTH-1:0] act_div_d  [NCH];
    logic [WIDTH-1:0] pend_div_q [NCH];
    logic [WIDTH-1:0] pend_div_d [NCH];
    logic [WIDTH-1:0] cnt_q      [NCH];
    logic [WIDTH-1:0] cnt_d      [NCH];
    logic [NCH-1:0]   act_mode_q, act_mode_d;
    logic [NCH-1:0]   pend_mode_q, pend_mode_d;
    logic [NCH-1:0]   pend_vld_q, pend_vld_d;
    logic [NCH-1:0]   run_q, run_d;
    logic [NCH-1:0]   cout_q, cout_d;
    logic [NCH-1:0]   tick_q, tick_d;
    logic             cfg_err_q, cfg_err_d;
    logic             cfg_ok;
    logic [NCH-1:0]   wr_hit;

    always_comb begin
        cfg_ok = cfg_we && (int'(cfg_ch) < NCH) && (cfg_div >= WIDTH'(2));
        for (int i = 0; i < NCH; i++) begin
            wr_hit[i] = cfg_ok && (int'(cfg_ch) == i);
        end
    end

    always_comb begin
        cfg_err_d   = cfg_we && !cfg_ok;
        act_mode_d  = act_mode_q;
        pend_mode_d = pend_mode_q;
        pend_vld_d  = pend_vld_q;
        run_d       = run_q;
        cout_d      = '0;
        tick_d      = '0;
        for (int i = 0; i < NCH; i++) begin
            act_div_d[i]  = act_div_q[i];
            pend_div_d[i] = pend_div_q[i];
            cnt_d[i]      = cnt_q[i];

            // Pending config is captured regardless of enable so a disabled
            // channel comes back up with its latest programmed ratio.
            if (wr_hit[i]) begin
                pend_div_d[i]  = cfg_div;
                pend_mode_d[i] = cfg_mode;
                pend_vld_d[i]  = 1'b1;
            end

            if (en[i]) begin
                if (!run_q[i] || sync_i || (cnt_q[i] == act_div_q[i] - WIDTH'(1))) begin
                    cnt_d[i] = '0;
                    run_d[i] = 1'b1;
                    if (wr_hit[i]) begin
                        act_div_d[i]  = cfg_div;
                        act_mode_d[i] = cfg_mode;
                        pend_vld_d[i] = 1'b0;
                    end else if (pend_vld_q[i]) begin
                        act_div_d[i]  = pend_div_q[i];
                        act_mode_d[i] = pend_mode_q[i];
                        pend_vld_d[i] = 1'b0;
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + WIDTH'(1);
                end
                tick_d[i] = (cnt_d[i] == '0);
                cout_d[i] = act_mode_d[i] ? (cnt_d[i] == '0)
                                          : (cnt_d[i] < (act_div_d[i] >> 1));
            end else begin
                cnt_d[i] = '0;
                run_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                act_div_q[i]  <= DEF_DIV;
                pend_div_q[i] <= DEF_DIV;
                cnt_q[i]      <= '0;
            end
            act_mode_q  <= '0;
            pend_mode_q <= '0;
            pend_vld_q  <= '0;
            run_q       <= '0;
            cout_q      <= '0;
            tick_q      <= '0;
            cfg_err_q   <= 1'b0;
        end else begin
            act_div_q   <= act_div_d;
            pend_div_q  <= pend_div_d;
            cnt_q       <= cnt_d;
            act_mode_q  <= act_mode_d;
            pend_mode_q <= pend_mode_d;
            pend_vld_q  <= pend_vld_d;
            run_q       <= run_d;
            cout_q      <= cout_d;
            tick_q      <= tick_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign cout    = cout_q;
    assign tick    = tick_q;
    assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_clk_divider_bank.sv
// Scoreboard bench for clk_divider_bank: a phase-based reference model queues
// expected outputs per cycle, a monitor pops and compares after each edge.
module tb_clk_divider_bank;

    localparam int NCH         = 10;
    localparam int WIDTH       = 16;
    localparam int DEFAULT_DIV = 2;
    localparam int CHW         = $clog2(NCH);

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NCH-1:0]   en;
    logic             sync_i;
    logic             cfg_we;
    logic [CHW-1:0]   cfg_ch;
    logic [WIDTH-1:0] cfg_div;
    logic             cfg_mode;
    logic             cfg_err;
    logic [NCH-1:0]   cout;
    logic [NCH-1:0]   tick;

    always #5 clk = ~clk;

    clk_divider_bank #(.NCH(NCH), .WIDTH(WIDTH), .DEFAULT_DIV(DEFAULT_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sync_i(sync_i),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_mode(cfg_mode),
        .cfg_err(cfg_err), .cout(cout), .tick(tick)
    );

    typedef struct packed {
        logic [NCH-1:0] cout;
        logic [NCH-1:0] tick;
        logic           err;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: each channel is described by its phase within the
    // current period (-1 when idle), its active ratio/mode and a pending slot.
    int m_d[NCH], m_pd[NCH], m_ph[NCH];
    bit m_m[NCH], m_pm[NCH], m_pv[NCH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        exp_t e;
        bit   acc;
        e = '0;
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                m_d[i] = DEFAULT_DIV; m_pd[i] = DEFAULT_DIV;
                m_m[i] = 0; m_pm[i] = 0; m_pv[i] = 0; m_ph[i] = -1;
            end
        end else begin
            acc   = cfg_we && (int'(cfg_ch) < NCH) && (int'(cfg_div) >= 2);
            e.err = cfg_we && !acc;
            for (int i = 0; i < NCH; i++) begin
                if (acc && int'(cfg_ch) == i) begin
                    m_pd[i] = int'(cfg_div); m_pm[i] = cfg_mode; m_pv[i] = 1;
                end
                if (!en[i]) begin
                    m_ph[i] = -1;
                end else begin
                    if (m_ph[i] < 0 || sync_i || m_ph[i] == m_d[i] - 1) begin
                        m_ph[i] = 0;
                        if (m_pv[i]) begin
                            m_d[i] = m_pd[i]; m_m[i] = m_pm[i]; m_pv[i] = 0;
                        end
                    end else begin
                        m_ph[i] = m_ph[i] + 1;
                    end
                    e.tick[i] = (m_ph[i] == 0);
                    e.cout[i] = m_m[i] ? (m_ph[i] == 0) : (m_ph[i] < m_d[i] / 2);
                end
            end
        end
        sb_q.push_back(e);
    endtask

    // Inputs are applied at the falling edge; the model predicts the next rise.
    task automatic step();
        model_step();
        @(negedge clk);
    endtask

    task automatic write(input int ch, input int d, input bit mode);
        cfg_we = 1'b1; cfg_ch = CHW'(ch); cfg_div = WIDTH'(d); cfg_mode = mode;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic steps_to_tick(input int ch, input int lim, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!tick[ch] && n < lim);
    endtask

    task automatic wait_tick(input int ch, input int lim, input string name);
        int n;
        n = 0;
        while (!tick[ch] && n < lim) begin
            step();
            n++;
        end
        check(name, 32'(tick[ch]), 32'd1);
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: no expected entry at %0t", $time);
            end else begin
                e = sb_q.pop_front();
                check("sb_cout", 32'(cout), 32'(e.cout));
                check("sb_tick", 32'(tick), 32'(e.tick));
                check("sb_cfg_err", 32'(cfg_err), 32'(e.err));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Driver
    initial begin
        logic [4:0] pat;
        int         n, highs;
        logic [NCH-1:0] all1;
        all1 = '1;
        rst_n = 1'b0; en = '0; sync_i = 1'b0;
        cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_mode = 1'b0;
        repeat (3) step();
        check("reset_cout", 32'(cout), 32'd0);
        check("reset_tick", 32'(tick), 32'd0);
        check("reset_err", 32'(cfg_err), 32'd0);

        rst_n = 1'b1; en = '1;
        step();
        check("start_cout", 32'(cout), 32'(all1));
        check("start_tick", 32'(tick), 32'(all1));
        step();
        check("div2_low", 32'(cout), 32'd0);
        step();
        check("div2_high", 32'(cout), 32'(all1));

        write(3, 5, 1'b0);
        write(4, 4, 1'b1);
        wait_tick(3, 12, "ch3_tick_seen");
        pat[0] = cout[3];
        for (int k = 1; k < 5; k++) begin
            step();
            pat[k] = cout[3];
        end
        check("ch3_pattern", 32'(pat), 32'b00011);
        wait_tick(4, 12, "ch4_tick_seen");
        highs = 0;
        repeat (8) begin
            step();
            highs += int'(cout[4]);
        end
        check("ch4_duty", 32'(highs), 32'd2);

        // Ratio change mid-period: old period finishes, last write wins.
        write(0, 8, 1'b0);
        wait_tick(0, 10, "ch0_d8_tick");
        step(); step();
        write(0, 3, 1'b0);
        write(0, 6, 1'b0);
        steps_to_tick(0, 20, n);
        check("ch0_old_tail", 32'(n), 32'd4);
        steps_to_tick(0, 20, n);
        check("ch0_new_period", 32'(n), 32'd6);

        // Phase realignment with one channel held off.
        write(1, 3, 1'b0);
        write(2, 5, 1'b0);
        write(5, 7, 1'b0);
        en[9] = 1'b0;
        repeat ($urandom_range(5, 15)) step();
        sync_i = 1'b1;
        step();
        sync_i = 1'b0;
        check("sync_ticks", 32'(tick), 32'(en));
        check("ch9_idle", 32'(cout[9]), 32'd0);
        repeat (10) step();

        // Rejected writes.
        write(0, 1, 1'b0);
        check("err_div1", 32'(cfg_err), 32'd1);
        step();
        check("err_div1_clear", 32'(cfg_err), 32'd0);
        write(1, 0, 1'b1);
        check("err_div0", 32'(cfg_err), 32'd1);
        write(NCH, 4, 1'b0);
        check("err_badch", 32'(cfg_err), 32'd1);
        step();
        check("err_badch_clear", 32'(cfg_err), 32'd0);
        repeat (8) step();

        // Randomized traffic.
        en = '1;
        for (int c = 0; c < 500; c++) begin
            if ($urandom_range(0, 5) == 0) begin
                cfg_we   = 1'b1;
                cfg_ch   = CHW'($urandom_range(0, (1 << CHW) - 1));
                cfg_div  = ($urandom_range(0, 4) == 0) ? WIDTH'($urandom_range(0, 1))
                                                       : WIDTH'($urandom_range(2, 12));
                cfg_mode = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 15) == 0) en[$urandom_range(0, NCH - 1)] ^= 1'b1;
            sync_i = ($urandom_range(0, 40) == 0);
            rst_n  = ($urandom_range(0, 200) != 0);
            step();
            cfg_we = 1'b0; sync_i = 1'b0; rst_n = 1'b1;
        end

        // Reset mid-period with writes still pending.
        en = '1;
        write(2, 9, 1'b0);
        write(7, 4, 1'b1);
        rst_n = 1'b0;
        step();
        check("rst_mid_cout", 32'(cout), 32'd0);
        check("rst_mid_tick", 32'(tick), 32'd0);
        rst_n = 1'b1;
        step();
        check("rst_rel_cout", 32'(cout), 32'(all1));
        step();
        check("rst_rel_low", 32'(cout), 32'd0);
        step();
        check("rst_rel_high", 32'(cout), 32'(all1));
        check("rst_rel_tick", 32'(tick), 32'(all1));
        repeat (4) step();

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
